sequential_sobel_y_stream: RTL and testbench
============================================

Name: sequential_sobel_Y_stream

Overview:
Streaming vertical-gradient (Sobel Y) engine. It complements the column-wise Sobel X cell by differentiating along the other image axis.
- Accepts raster-order 8-bit pixels and keeps the two previous rows in internal line buffers.
- Forms a 3x3 window and applies horizontal [1 2 1] smoothing to the bottom and top rows.
- Emits |bottom - top| for every interior pixel, tagged with its coordinates.
- Sits beside the Sobel X path, feeding the gradient-magnitude combiner.

Parameters:
IMG_WIDTH, 64, pixels per row (>=3)
IMG_HEIGHT, 64, rows per frame (>=3)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
pixel_in  input  8  incoming pixel, raster order
pixel_valid  input  1  pixel_in valid this cycle; no backpressure
sof  input  1  start of frame, qualified by pixel_valid; marks pixel (0,0)
sobel_Y_out  output  10  |Gy| magnitude of the centre pixel
out_valid  output  1  sobel_Y_out/out_row/out_col valid this cycle
out_row  output  $clog2(IMG_HEIGHT)  row of the centre pixel
out_col  output  $clog2(IMG_WIDTH)  column of the centre pixel
frame_done  output  1  one-cycle pulse coincident with the last interior output of a full frame

Behaviour:
- Reset (async, rst_n=0):
  - Clears all outputs to 0, row/col counters to 0, and pipeline valid bits to 0.
  - Line buffer and window contents are not reset. Their values are don't-care because the border masking below ignores them.
- Input counters:
  - An accepted pixel is pixel_valid=1 at position (r,c). Each accepted pixel advances c; at c=IMG_WIDTH-1, c wraps to 0 and r increments.
  - After (IMG_HEIGHT-1, IMG_WIDTH-1), the counters wrap to (0,0) with no sof required.
  - sof=1 with pixel_valid forces the current pixel to be (0,0), even mid-frame.
  - pixel_valid=0: nothing advances, and no window or line-buffer write occurs.
- Window:
  - Two line buffers (IMG_WIDTH x 8) supply rows r-1 and r-2 at column c.
  - Three 3-deep column shift registers hold columns c-2, c-1 and c for rows r-2, r-1 and r.
- Arithmetic:
  - S_bot = p[r][c-2] + 2*p[r][c-1] + p[r][c], 10 bits unsigned, max 1020. S_top is the same for row r-2.
  - Gy = S_bot - S_top, 11-bit two's complement.
  - sobel_Y_out = Gy<0 ? -Gy : Gy, giving 10 bits with max 1020. No overflow is possible.
- Border: a result is produced only when the accepted pixel has r>=2 and c>=2. The centre pixel is (r-1, c-1).
  - This yields (IMG_HEIGHT-2)*(IMG_WIDTH-2) outputs per frame.
  - Border pixels produce no output.
- Latency: two clocks.
  - Stage 1 registers S_bot, S_top, the coordinates and valid.
  - Stage 2 registers magnitude, out_valid, out_row and out_col.
  - A pixel accepted on edge N produces out_valid=1 after edge N+2.
- Throughput: one result per accepted pixel at full rate. Gaps in pixel_valid propagate as gaps in out_valid.
- frame_done: asserted with the output whose centre is (IMG_HEIGHT-2, IMG_WIDTH-2). It is asserted only if that frame ran from an sof or counter wrap without restart.
- sof mid-frame:
  - Results already in the two pipeline stages still emerge.
  - No frame_done is asserted for the abandoned frame.
  - The new frame begins border masking at row 0.
- Outputs hold their last value while out_valid=0. frame_done is 0 except during its pulse.

Optional Feature:
SOBEL_Y_SATURATE_EN
- Defined: the magnitude is clamped to 255 (sobel_Y_out = min(|Gy|,255), so bits [9:8] are always 0), for direct 8-bit display. Latency is unchanged.
- Undefined: the full 10-bit magnitude (0..1020) is output.

Test Plan:
(bench: IMG_WIDTH=8, IMG_HEIGHT=6)
- Uniform frame, all pixels 77, continuous valid with sof on the first pixel -> 24 outputs, all 0. Coordinates run rows 1..4 and cols 1..6 in raster order. frame_done fires with (4,6) exactly 2 clocks after the last pixel.
- Step edge, rows 0-2=0 and rows 3-5=200 -> centre rows 2 and 3 give 800, rows 1 and 4 give 0. With SOBEL_Y_SATURATE_EN the edge rows give 255.
- Inverted edge, rows 0-2=255 and rows 3-5=0 -> centre rows 2 and 3 give 1020 (negative Gy, magnitude taken). Saturated build gives 255.
- Same step-edge frame with pixel_valid toggling 1,0,0,1,... -> identical value/coordinate sequence, with out_valid gaps mirroring the input gaps.
- sof re-asserted at pixel (3,4) of the step frame -> the two in-flight results still appear. No frame_done for that frame. The new frame's first output appears 2 clocks after its pixel (2,2).
- rst_n pulsed low mid-frame -> out_valid, frame_done and sobel_Y_out go 0 immediately. After release, the next frame (with sof) yields the correct 24 results.

Source files
------------

// File: rtl/sequential_sobel_y_stream.sv
// Streaming Sobel-Y engine: two line buffers, 3x3 window, |[1 2 1]*bottom - [1 2 1]*top| per interior pixel.
// Optional build macro SOBEL_Y_SATURATE_EN clamps the magnitude to 255.
module sequential_sobel_y_stream #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    pixel_in,
    input  logic                          pixel_valid,
    input  logic                          sof,
    output logic [9:0]                    sobel_Y_out,
    output logic                          out_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic                          frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [7:0]      lb1_q [IMG_WIDTH];
    logic [7:0]      lb2_q [IMG_WIDTH];
    logic [2:0][7:0] bot_q;
    logic [2:0][7:0] top_q;

    logic [RW-1:0] row_q, row_d, cur_row_s;
    logic [CW-1:0] col_q, col_d, cur_col_s;
    logic          started_q, started_d;
    logic          interior_s, last_s;

    logic          win_vld_q, win_last_q;
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;

    logic          s1_vld_q, s1_last_q;
    logic [9:0]    s_bot_q, s_top_q, s_bot_s, s_top_s;
    logic [RW-1:0] s1_row_q;
    logic [CW-1:0] s1_col_q;

    logic [9:0]    abs_s, mag_s;
    logic [9:0]    mag_q;
    logic          out_valid_q, frame_done_q;
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    // Coordinate of the pixel on the input this cycle and the counter advance
    always_comb begin
        cur_row_s = row_q;
        cur_col_s = col_q;
        row_d     = row_q;
        col_d     = col_q;
        started_d = started_q;
        if (pixel_valid && sof) begin
            cur_row_s = '0;
            cur_col_s = '0;
            started_d = 1'b1;
        end else begin
            cur_row_s = row_q;
            cur_col_s = col_q;
        end
        if (pixel_valid) begin
            if (cur_col_s == COL_LAST) begin
                col_d = '0;
                if (cur_row_s == ROW_LAST) begin
                    row_d     = '0;
                    started_d = 1'b1;
                end else begin
                    row_d = cur_row_s + RW'(1);
                end
            end else begin
                col_d = cur_col_s + CW'(1);
                row_d = cur_row_s;
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
        interior_s = pixel_valid && (cur_row_s >= ROW_TWO) && (cur_col_s >= COL_TWO);
        last_s     = started_q && (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
    end

    // Horizontal [1 2 1] smoothing and absolute difference; started_q only marks frames with a defined origin
    always_comb begin
        s_bot_s = {2'b00, bot_q[0]} + {1'b0, bot_q[1], 1'b0} + {2'b00, bot_q[2]};
        s_top_s = {2'b00, top_q[0]} + {1'b0, top_q[1], 1'b0} + {2'b00, top_q[2]};
        if (s_bot_q >= s_top_q) begin
            abs_s = s_bot_q - s_top_q;
        end else begin
            abs_s = s_top_q - s_bot_q;
        end
`ifdef SOBEL_Y_SATURATE_EN
        if (abs_s > 10'd255) begin
            mag_s = 10'd255;
        end else begin
            mag_s = abs_s;
        end
`else
        mag_s = abs_s;
`endif
    end

    // Line buffers and window columns: pure data, masked by the border logic so never reset
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            lb1_q[cur_col_s] <= pixel_in;
            lb2_q[cur_col_s] <= lb1_q[cur_col_s];
            bot_q            <= {pixel_in, bot_q[2:1]};
            top_q            <= {lb2_q[cur_col_s], top_q[2:1]};
        end
    end

    // Input counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q     <= '0;
            col_q     <= '0;
            started_q <= 1'b0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            started_q <= started_d;
        end
    end

    // Window tag, stage 1 (sums) and stage 2 (magnitude / outputs)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_vld_q    <= 1'b0;
            win_last_q   <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            s1_vld_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            s_bot_q      <= 10'd0;
            s_top_q      <= 10'd0;
            s1_row_q     <= '0;
            s1_col_q     <= '0;
            mag_q        <= 10'd0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_row_q    <= '0;
            out_col_q    <= '0;
        end else begin
            win_vld_q  <= interior_s;
            win_last_q <= interior_s && last_s;
            if (interior_s) begin
                win_row_q <= cur_row_s - RW'(1);
                win_col_q <= cur_col_s - CW'(1);
            end
            s1_vld_q  <= win_vld_q;
            s1_last_q <= win_last_q;
            s_bot_q   <= s_bot_s;
            s_top_q   <= s_top_s;
            s1_row_q  <= win_row_q;
            s1_col_q  <= win_col_q;
            out_valid_q  <= s1_vld_q;
            frame_done_q <= s1_vld_q && s1_last_q;
            if (s1_vld_q) begin
                mag_q     <= mag_s;
                out_row_q <= s1_row_q;
                out_col_q <= s1_col_q;
            end
        end
    end

    assign sobel_Y_out = mag_q;
    assign out_valid   = out_valid_q;
    assign out_row     = out_row_q;
    assign out_col     = out_col_q;
    assign frame_done  = frame_done_q;
endmodule

// File: tb/tb_sequential_sobel_y_stream.sv
// Scoreboard bench for sequential_sobel_y_stream on an 8x6 image.
module tb_sequential_sobel_y_stream;
    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pixel_in;
    logic       pixel_valid;
    logic       sof;
    logic [9:0] sobel_Y_out;
    logic       out_valid;
    logic [2:0] out_row;
    logic [2:0] out_col;
    logic       frame_done;

    sequential_sobel_y_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .sof(sof),
        .sobel_Y_out(sobel_Y_out), .out_valid(out_valid), .out_row(out_row), .out_col(out_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mag;
        int row;
        int col;
        int last;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out = 0;
    int   n_done = 0;
    int   frm[H][W];
    int   mr, mc;
    bit   started;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic int exp_mag(input int r, input int c);
        int sb, st, g;
        sb = frm[r][c-2] + 2 * frm[r][c-1] + frm[r][c];
        st = frm[r-2][c-2] + 2 * frm[r-2][c-1] + frm[r-2][c];
        g  = (sb >= st) ? sb - st : st - sb;
`ifdef SOBEL_Y_SATURATE_EN
        if (g > 255) g = 255;
`endif
        return g;
    endfunction

    function automatic int pix(input int kind, input int r);
        case (kind)
            0:       return 77;
            1:       return (r < 3) ? 0 : 200;
            2:       return (r < 3) ? 255 : 0;
            default: return 0;
        endcase
    endfunction

    // Output monitor: every valid output is matched against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            n_out++;
            if (frame_done) n_done++;
            if (q.size() == 0) begin
                check_eq("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                check_eq("mag", int'(sobel_Y_out), e.mag);
                check_eq("row", int'(out_row), e.row);
                check_eq("col", int'(out_col), e.col);
                check_eq("frame_done", int'(frame_done), e.last);
                check_eq("latency", cyc, e.cyc);
            end
        end else if (rst_n && frame_done) begin
            check_eq("done_without_valid", 1, 0);
        end
    end

    task automatic drive_pix(input int val, input bit s);
        exp_t e;
        @(negedge clk);
        pixel_in    = 8'(val);
        pixel_valid = 1'b1;
        sof         = s;
        if (s) begin
            mr = 0;
            mc = 0;
            started = 1'b1;
        end
        frm[mr][mc] = val;
        if (mr >= 2 && mc >= 2) begin
            e.mag  = exp_mag(mr, mc);
            e.row  = mr - 1;
            e.col  = mc - 1;
            e.last = (started && mr == H - 1 && mc == W - 1) ? 1 : 0;
            e.cyc  = cyc + 3;
            q.push_back(e);
        end
        if (mc == W - 1) begin
            mc = 0;
            if (mr == H - 1) begin
                mr = 0;
                started = 1'b1;
            end else begin
                mr++;
            end
        end else begin
            mc++;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        pixel_valid = 1'b0;
        sof         = 1'b0;
        pixel_in    = 8'($urandom_range(0, 255));
    endtask

    // Drives one frame (sof on pixel 0); stops before raster index stop_idx when >= 0
    task automatic run_frame(input int kind, input bit gap, input int stop_idx);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (stop_idx >= 0 && r * W + c == stop_idx) return;
                drive_pix(pix(kind, r), (r == 0 && c == 0));
                if (gap) begin
                    idle();
                    idle();
                end
            end
        end
    endtask

    task automatic drain(input int want_out, input int want_done);
        for (int i = 0; i < 12; i++) begin
            if (q.size() == 0) break;
            idle();
        end
        check_eq("drain", q.size(), 0);
        repeat (3) idle();
        check_eq("n_out", n_out, want_out);
        check_eq("n_done", n_done, want_done);
        n_out  = 0;
        n_done = 0;
    endtask

    initial begin
        rst_n       = 1'b0;
        pixel_in    = 8'd0;
        pixel_valid = 1'b0;
        sof         = 1'b0;
        mr = 0;
        mc = 0;
        started = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_valid", int'(out_valid), 0);
        check_eq("rst_done", int'(frame_done), 0);
        check_eq("rst_mag", int'(sobel_Y_out), 0);
        check_eq("rst_row", int'(out_row), 0);
        check_eq("rst_col", int'(out_col), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(0, 1'b0, -1);
        drain(24, 1);
        run_frame(1, 1'b0, -1);
        drain(24, 1);
        run_frame(2, 1'b0, -1);
        drain(24, 1);
        run_frame(1, 1'b1, -1);
        drain(24, 1);

        // Restart at (3,4): 8 in-flight/earlier results from the abandoned frame, then a full frame
        run_frame(1, 1'b0, 3 * W + 4);
        run_frame(1, 1'b0, -1);
        drain(32, 1);

        // Asynchronous reset while edge-row results are on the outputs
        run_frame(2, 1'b0, 3 * W + 5);
        idle();
        check_eq("pre_rst_mag", int'(sobel_Y_out), pix(2, 0) * 4);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", int'(out_valid), 0);
        check_eq("arst_done", int'(frame_done), 0);
        check_eq("arst_mag", int'(sobel_Y_out), 0);
        q.delete();
        mr = 0;
        mc = 0;
        started = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        n_out  = 0;
        n_done = 0;
        run_frame(1, 1'b0, -1);
        drain(24, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
